// File: rtl/dbus_bridge_pkg.sv
// Shared types and helpers for the data-bus bridge: FSM encoding, bus size codes,
// byte-select decoding and the fill word returned when a transaction times out.
package dbus_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_t;

    localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

    // Unrecognised lane patterns fall back to a full-word access.
    function automatic size_t sel_to_size(input logic [3:0] sel);
        case (sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return SIZE_BYTE;
            4'b0011, 4'b1100:                   return SIZE_HALF;
            default:                            return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/dbus_bridge_if.sv
// External data-bus signal bundle: request/address-ok/data-ok handshake.
// The bridge drives the master modport; the memory system sits on the slave modport.
interface dbus_bridge_if #(
    parameter int ADDR_W = 32
) ();

    logic              data_req_o;
    logic              data_wr_o;
    logic [1:0]        data_size_o;
    logic [ADDR_W-1:0] data_addr_o;
    logic [3:0]        data_wstrb_o;
    logic [31:0]       data_wdata_o;
    logic              data_addr_ok_i;
    logic              data_data_ok_i;
    logic [31:0]       data_rdata_i;

    modport master (
        output data_req_o, data_wr_o, data_size_o, data_addr_o, data_wstrb_o, data_wdata_o,
        input  data_addr_ok_i, data_data_ok_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_wr_o, data_size_o, data_addr_o, data_wstrb_o, data_wdata_o,
        output data_addr_ok_i, data_data_ok_i, data_rdata_i
    );

endinterface

// File: rtl/dbus_bridge_watchdog.sv
// Wait-state watchdog for the data-bus bridge: counts WAIT cycles since the request
// was accepted and flags expiry during the TIMEOUT_CYCLES-th one.
module dbus_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;

    // Cleared on entry to WAIT, then advanced once per WAIT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= '0;
        end else if (active && !expired) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign expired = active && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/dbus_bridge.sv
// Memory-stage to external data-bus bridge: turns each single-cycle access into a
// req/addr_ok/data_ok transaction. Optional data_ok timeout under DBUS_TIMEOUT_EN.
module dbus_bridge
    import dbus_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
`ifdef DBUS_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic              flush_i,
    output logic [31:0]       mem_rdata_o,
    output logic              stallreq_o,
`ifdef DBUS_TIMEOUT_EN
    output logic              bus_err_o,
`endif
    dbus_bridge_if.master     bus
);

    state_t            state_q, state_d;
    logic              we_q;
    logic [3:0]        sel_q;
    size_t             size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              flushed_q;
    logic              accept;
    logic              drop;
    logic              complete;
    logic              timed_out;

    assign accept   = mem_ce_i & ~flush_i;
    assign drop     = flushed_q | flush_i;
    assign complete = (state_q == ST_WAIT) & (bus.data_data_ok_i | timed_out);

`ifdef DBUS_TIMEOUT_EN
    logic wd_expired;
    logic bus_err_q;

    dbus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  ((state_q == ST_REQ) & bus.data_addr_ok_i),
        .active (state_q == ST_WAIT),
        .expired(wd_expired)
    );

    assign timed_out = wd_expired & ~bus.data_data_ok_i;

    // One-cycle error pulse, coincident with the DONE cycle carrying the fill word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= (state_q == ST_WAIT) & timed_out & ~drop;
        end
    end

    assign bus_err_o = bus_err_q;
`else
    assign timed_out = 1'b0;
`endif

    // A data_ok seen while still in REQ is deliberately ignored; the bus re-presents it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_REQ;
            ST_REQ:  if (bus.data_addr_ok_i) state_d = ST_WAIT;
            ST_WAIT: if (complete) state_d = drop ? ST_IDLE : ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are captured once in IDLE and held for the whole transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            sel_q   <= 4'b0000;
            size_q  <= SIZE_BYTE;
            addr_q  <= '0;
            wdata_q <= 32'h0;
        end else if ((state_q == ST_IDLE) && accept) begin
            we_q    <= mem_we_i;
            sel_q   <= mem_sel_i;
            size_q  <= sel_to_size(mem_sel_i);
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
        end
    end

    // An issued request cannot be withdrawn, so a flush only marks its result for discard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flushed_q <= 1'b0;
        end else if (state_d == ST_IDLE) begin
            flushed_q <= 1'b0;
        end else if (((state_q == ST_REQ) || (state_q == ST_WAIT)) && flush_i) begin
            flushed_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rdata_o <= 32'h0;
        end else if ((state_q == ST_WAIT) && bus.data_data_ok_i && !drop && !we_q) begin
            mem_rdata_o <= bus.data_rdata_i;
`ifdef DBUS_TIMEOUT_EN
        end else if ((state_q == ST_WAIT) && timed_out && !drop) begin
            mem_rdata_o <= TIMEOUT_FILL;
`endif
        end
    end

    // Reset gates the stall so every output reads 0 while rst is low.
    assign stallreq_o = rst & mem_ce_i & ~flush_i & ~((state_q == ST_DONE) & ~flushed_q);

    assign bus.data_req_o   = (state_q == ST_REQ);
    assign bus.data_wr_o    = we_q;
    assign bus.data_size_o  = size_q;
    assign bus.data_addr_o  = addr_q;
    assign bus.data_wstrb_o = sel_q;
    assign bus.data_wdata_o = wdata_q;

endmodule

// File: tb/tb_dbus_bridge.sv
// Self-checking bench for dbus_bridge: directed scenarios plus randomized accesses
// against a transaction-level model. Define DBUS_TIMEOUT_EN to exercise the watchdog.
module tb_dbus_bridge;

    logic        clk;
    logic        rst;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        flush_i;
    logic [31:0] mem_rdata_o;
    logic        stallreq_o;
`ifdef DBUS_TIMEOUT_EN
    logic        bus_err_o;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_rdata = 32'h0;
    logic [3:0]  legal_sel [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    int          tmo_stall;
    int          tmo_cyc;
    int          tmo_err_early;

    dbus_bridge_if #(.ADDR_W(32)) bus ();

    dbus_bridge #(
        .ADDR_W(32)
`ifdef DBUS_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce_i   (mem_ce_i),
        .mem_we_i   (mem_we_i),
        .mem_sel_i  (mem_sel_i),
        .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .flush_i    (flush_i),
        .mem_rdata_o(mem_rdata_o),
        .stallreq_o (stallreq_o),
`ifdef DBUS_TIMEOUT_EN
        .bus_err_o  (bus_err_o),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Bus size code derived from the number of enabled byte lanes.
    function automatic logic [31:0] modelSize(input logic [3:0] sel);
        int lanes = 0;
        for (int i = 0; i < 4; i++) lanes += int'(sel[i]);
        if (lanes == 1) return 32'd0;
        if (lanes == 2) return 32'd1;
        return 32'd2;
    endfunction

    // Plays the pipeline (holding the access) and the bus slave (addr_ok after addr_delay
    // REQ cycles, data_ok after data_delay WAIT cycles), then checks the whole transaction.
    task automatic applyStimulus(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int addr_delay, input int data_delay, input bit same_cycle_ok,
                                 input string tag);
        int  cyc = 0;
        int  req_cnt = 0;
        int  wait_cnt = 0;
        int  stall_cnt = 0;
        bit  addr_done = 0;
        bit  data_done = 0;
        bit  fields_ok = 1;
        if (!we) exp_rdata = rdata;
        while (!data_done && cyc < 60) begin
            @(negedge clk);
            mem_ce_i = 1'b1; mem_we_i = we; mem_sel_i = sel;
            mem_addr_i = addr; mem_wdata_i = wdata; flush_i = 1'b0;
            bus.data_addr_ok_i = 1'b0; bus.data_data_ok_i = 1'b0; bus.data_rdata_i = $urandom;
            if (bus.data_req_o) begin
                if (bus.data_wr_o !== we || 32'(bus.data_size_o) !== modelSize(sel) ||
                    bus.data_wstrb_o !== sel || bus.data_addr_o !== addr || bus.data_wdata_o !== wdata)
                    fields_ok = 0;
                if (req_cnt == addr_delay) begin
                    bus.data_addr_ok_i = 1'b1;
                    addr_done = 1;
                    if (same_cycle_ok) begin
                        bus.data_data_ok_i = 1'b1;
                        bus.data_rdata_i = ~rdata;
                    end
                end
                req_cnt++;
            end else if (addr_done) begin
                if (wait_cnt == data_delay) begin
                    bus.data_data_ok_i = 1'b1;
                    bus.data_rdata_i = rdata;
                    data_done = 1;
                end
                wait_cnt++;
            end
            #1;
            if (stallreq_o) stall_cnt++;
            cyc++;
        end
        checkOutput({tag, "_completed"}, 32'(data_done), 32'd1);
        checkOutput({tag, "_bus_fields"}, 32'(fields_ok), 32'd1);
        checkOutput({tag, "_req_cycles"}, 32'(req_cnt), 32'(addr_delay + 1));
        checkOutput({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(addr_delay + data_delay + 3));
        @(negedge clk);
        bus.data_addr_ok_i = 1'b0; bus.data_data_ok_i = 1'b0;
        #1;
        checkOutput({tag, "_done_stall"}, 32'(stallreq_o), 32'd0);
        checkOutput({tag, "_done_rdata"}, mem_rdata_o, exp_rdata);
`ifdef DBUS_TIMEOUT_EN
        checkOutput({tag, "_done_bus_err"}, 32'(bus_err_o), 32'd0);
`endif
        mem_ce_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0;
        mem_addr_i = 32'h0; mem_wdata_i = 32'h0; flush_i = 1'b0;
        bus.data_addr_ok_i = 1'b0; bus.data_data_ok_i = 1'b0; bus.data_rdata_i = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_req", 32'(bus.data_req_o), 32'd0);
        checkOutput("reset_stall", 32'(stallreq_o), 32'd0);
        checkOutput("reset_wr", 32'(bus.data_wr_o), 32'd0);
        checkOutput("reset_size", 32'(bus.data_size_o), 32'd0);
        checkOutput("reset_addr", bus.data_addr_o, 32'd0);
        checkOutput("reset_wstrb", 32'(bus.data_wstrb_o), 32'd0);
        checkOutput("reset_rdata", mem_rdata_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] load word");
        applyStimulus(1'b0, 4'b1111, 32'h0000_1000, 32'h0, 32'h1234_5678, 0, 1, 0, "load_word");

        $display("[TB] store byte with delayed addr_ok");
        applyStimulus(1'b1, 4'b0100, 32'h0000_2002, 32'h00AB_0000, 32'h0, 3, 0, 0, "store_byte");

        $display("[TB] halfword with same-cycle addr_ok and data_ok");
        applyStimulus(1'b0, 4'b1100, 32'h0000_2804, 32'h0, 32'hCAFE_0000, 0, 1, 1, "half_same_ok");

        $display("[TB] flush in WAIT with a following access draining");
        @(negedge clk);
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h0000_3000; flush_i = 1'b0;
        #1;
        checkOutput("flush_idle_stall", 32'(stallreq_o), 32'd1);
        @(negedge clk);
        bus.data_addr_ok_i = 1'b1;
        #1;
        checkOutput("flush_req", 32'(bus.data_req_o), 32'd1);
        @(negedge clk);
        bus.data_addr_ok_i = 1'b0; mem_ce_i = 1'b0; flush_i = 1'b1;
        #1;
        checkOutput("flush_wait_req", 32'(bus.data_req_o), 32'd0);
        @(negedge clk);
        flush_i = 1'b0; mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
        mem_addr_i = 32'h0000_4000; mem_wdata_i = 32'h0000_BEEF;
        #1;
        checkOutput("drain_stall", 32'(stallreq_o), 32'd1);
        @(negedge clk);
        bus.data_data_ok_i = 1'b1; bus.data_rdata_i = 32'hFFFF_FFFF;
        #1;
        checkOutput("drain_ok_stall", 32'(stallreq_o), 32'd1);
        applyStimulus(1'b1, 4'b0011, 32'h0000_4000, 32'h0000_BEEF, 32'h0, 0, 0, 0, "post_drain");
        checkOutput("flush_rdata_kept", mem_rdata_o, exp_rdata);

        $display("[TB] asynchronous reset while requesting");
        @(negedge clk);
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b1111;
        mem_addr_i = 32'h0000_5000; mem_wdata_i = 32'h5555_AAAA;
        @(negedge clk);
        #1;
        checkOutput("rst_pre_req", 32'(bus.data_req_o), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_req", 32'(bus.data_req_o), 32'd0);
        checkOutput("rst_stall", 32'(stallreq_o), 32'd0);
        checkOutput("rst_wr", 32'(bus.data_wr_o), 32'd0);
        checkOutput("rst_addr", bus.data_addr_o, 32'd0);
        checkOutput("rst_wdata", bus.data_wdata_o, 32'd0);
        checkOutput("rst_rdata", mem_rdata_o, 32'd0);
        exp_rdata = 32'h0;
        @(negedge clk);
        mem_ce_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 4'b0001, 32'h0000_6001, 32'h0, 32'h0000_0077, 1, 0, 0, "after_reset");

        $display("[TB] randomized accesses");
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'($urandom_range(1, 0)), legal_sel[$urandom_range(6, 0)], $urandom, $urandom,
                          $urandom, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                          1'($urandom_range(1, 0)), $sformatf("rand%0d", n));
        end

`ifdef DBUS_TIMEOUT_EN
        $display("[TB] data_ok timeout");
        tmo_stall = 0; tmo_cyc = 0; tmo_err_early = 0;
        @(negedge clk);
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'b1111; mem_addr_i = 32'h0000_7000;
        bus.data_addr_ok_i = 1'b0; bus.data_data_ok_i = 1'b0;
        #1;
        if (stallreq_o) tmo_stall++;
        do begin
            @(negedge clk);
            bus.data_addr_ok_i = bus.data_req_o; bus.data_data_ok_i = 1'b0;
            #1;
            if (stallreq_o) tmo_stall++;
            if (stallreq_o && bus_err_o) tmo_err_early++;
            tmo_cyc++;
        end while (stallreq_o && tmo_cyc < 40);
        checkOutput("tmo_stall_cycles", 32'(tmo_stall), 32'd10);
        checkOutput("tmo_err_early", 32'(tmo_err_early), 32'd0);
        checkOutput("tmo_bus_err", 32'(bus_err_o), 32'd1);
        checkOutput("tmo_rdata", mem_rdata_o, 32'hDEAD_BEEF);
        mem_ce_i = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("tmo_err_pulse", 32'(bus_err_o), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dbus_bridge.md
Name: dbus_bridge

Overview:
- Sits directly downstream of the memory-access stage. Consumes its chip-enable, write-enable, byte-select, address and store-data outputs, and returns load data to that stage's memory-data input.
- Converts each single-cycle memory access into a request/address-ok/data-ok transaction on the external data bus.
- Raises a stall request to the pipeline controller until the transaction completes.
- Drops the result of any access flushed by an exception.

Parameters:
- TIMEOUT_CYCLES, 256: data_ok wait limit; used only with the optional feature.
- ADDR_W, 32: bus address width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- mem_ce_i  in  1  memory access valid this cycle.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_sel_i  in  4  byte lanes: 0001/0010/0100/1000, 0011/1100, or 1111.
- mem_addr_i  in  ADDR_W  physical byte address.
- mem_wdata_i  in  32  lane-aligned store data.
- flush_i  in  1  exception flush of the instruction in the memory stage.
- mem_rdata_o  out  32  raw 32-bit load word, returned to the memory stage.
- stallreq_o  out  1  hold the pipeline.
- data_req_o  out  1  bus request.
- data_wr_o  out  1  bus write.
- data_size_o  out  2  0 = byte, 1 = half, 2 = word.
- data_addr_o  out  ADDR_W  bus address.
- data_wstrb_o  out  4  write strobes (= latched sel).
- data_wdata_o  out  32  write data.
- data_addr_ok_i  in  1  request accepted.
- data_data_ok_i  in  1  read data valid / write done.
- data_rdata_i  in  32  read data.
- bus_err_o  out  1  timeout flag; present only with the optional feature.

Behaviour:
- State machine: IDLE, REQ, WAIT, DONE. Reset (rst = 0, any time, including mid-transaction) forces IDLE.
- All outputs reset to 0. Internal state also clears: flushed_q = 0, latched fields = 0, mem_rdata_o = 0.
- IDLE:
  - If mem_ce_i = 1 and flush_i = 0: latch we, sel, addr and wdata.
  - data_size from sel: single lane -> 0, two lanes -> 1, 1111 -> 2; any other value -> 2.
  - Go to REQ next cycle. Otherwise stay in IDLE.
- REQ:
  - data_req_o = 1; all bus fields driven from the latches and held stable until data_addr_ok_i.
  - On data_addr_ok_i = 1 -> WAIT; data_req_o drops in the same edge.
  - data_data_ok_i is ignored in REQ.
- WAIT:
  - On data_data_ok_i = 1: if not flushed_q, capture data_rdata_i into mem_rdata_o (loads only) and go to DONE.
  - If flushed_q, go to IDLE with mem_rdata_o unchanged.
- DONE: one cycle; result presented, stall released. Next state IDLE. A new mem_ce_i in DONE is not accepted until the following IDLE cycle.
- stallreq_o (combinational) = mem_ce_i & ~flush_i & ~(state == DONE & ~flushed_q).
  - Minimum stall for an access is 3 cycles: addr_ok in the first REQ cycle, data_ok in the first WAIT cycle.
  - A new access arriving while an earlier flushed transaction is still draining stalls until IDLE.
- Flush rules:
  - flush_i in IDLE: no request issued.
  - flush_i in REQ or WAIT: set flushed_q. The request cannot be withdrawn, so REQ still waits for addr_ok and WAIT still waits for data_ok; the result is discarded.
  - flush_i in DONE: no effect.
  - flushed_q clears on entry to IDLE.
- Stores complete on data_data_ok_i and leave mem_rdata_o unchanged.
- addr_ok and data_ok in the same REQ cycle: only addr_ok is honoured; the bus must re-present data_ok.

Optional Feature:
- Macro DBUS_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no data_ok: go to DONE, set mem_rdata_o = 32'hDEADBEEF, and pulse bus_err_o for 1 cycle. The memory stage turns this pulse into a bus-error exception.
- Undefined: no counter, no bus_err_o port; WAIT lasts indefinitely.

Decomposition:
- Shared package:
  - state encoding (IDLE = 0, REQ = 1, WAIT = 2, DONE = 3);
  - size codes;
  - sel-to-size function;
  - timeout fill constant.
- Sub-module dbus_watchdog (counter plus compare), instantiated only under DBUS_TIMEOUT_EN.

Test Plan:
- Load-word:
  - Stimulus: ce = 1, we = 0, sel = 1111, addr = 0x00001000; addr_ok in cycle 1 of REQ; data_ok with rdata = 0x12345678 after 2 WAIT cycles.
  - Required: size = 2, req high exactly 1 cycle, stall high 4 cycles, mem_rdata_o = 0x12345678 in DONE.
- Store-byte:
  - Stimulus: sel = 0100, wdata = 0x00AB0000, addr = 0x2002.
  - Required: wr = 1, size = 0, wstrb = 0100, data held until addr_ok (delayed 3 cycles), stall releases in DONE, mem_rdata_o unchanged.
- Flush in WAIT:
  - Stimulus: flush_i pulsed in WAIT, then data_ok with rdata = 0xFFFFFFFF.
  - Required: no DONE, mem_rdata_o keeps its old value, FSM returns to IDLE. A following access issued during the drain stalls until IDLE.
- Reset mid-REQ:
  - Stimulus: rst = 0 asynchronously while req = 1.
  - Required: req, stall and every output go to 0 immediately; IDLE after release.
- Halfword size:
  - Stimulus: sel = 1100.
  - Required: size = 1. Same-cycle addr_ok + data_ok in REQ: data_ok ignored, completion only on a later data_ok.
- DBUS_TIMEOUT_EN, TIMEOUT_CYCLES = 8:
  - Stimulus: no data_ok.
  - Required: bus_err_o pulses after 8 WAIT cycles, mem_rdata_o = 0xDEADBEEF, stall released.
